// File: rtl/sd_crc_lanes.sv
// Per-lane serial CRC engine for the SD DAT path: accumulates a block, then emits (TX) or checks (RX) the CRC.
// dout is registered one cycle after each din_valid strobe; no backpressure, the engine holds state between strobes.
module sd_crc_lanes #(
  parameter int                LANES = 4,
  parameter int                CRC_W = 16,
  parameter logic [CRC_W-1:0]  POLY  = 16'h1021,
  parameter int                LEN_W = 13
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   start,
  input  logic                   mode,
  input  logic [LEN_W-1:0]       blk_len,
  input  logic                   din_valid,
  input  logic [LANES-1:0]       din,
  output logic                   dout_valid,
  output logic [LANES-1:0]       dout,
  output logic                   busy,
  output logic                   crc_phase,
  output logic                   done,
  output logic [LANES-1:0]       crc_err,
  output logic [LANES*CRC_W-1:0] crc_val
);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_CRCP, S_DONE} state_t;

  localparam logic [LEN_W-1:0] CRC_LAST = LEN_W'(CRC_W - 1);

  state_t                        state, state_nxt;
  logic                          mode_q;
  logic [LEN_W-1:0]              len_q;
  logic [LEN_W-1:0]              cnt;
  logic [LANES-1:0][CRC_W-1:0]   crc;
  logic [LANES-1:0][CRC_W-1:0]   crc_fb;
  logic [LANES-1:0][CRC_W-1:0]   crc_sh;
  logic [LANES-1:0][CRC_W-1:0]   crc_val_q;
  logic [LANES-1:0]              crc_msb;
  logic                          accept;
  logic                          data_last;

  always_ff @(posedge CLK) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    data_last = 1'b0;
    busy      = 1'b0;
    crc_phase = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = (blk_len == '0) ? S_CRCP : S_DATA;
        end
      end
      S_DATA: begin
        busy = 1'b1;
        if (din_valid && (cnt == len_q - LEN_W'(1))) begin
          data_last = 1'b1;
          state_nxt = S_CRCP;
        end
      end
      S_CRCP: begin
        busy      = 1'b1;
        crc_phase = 1'b1;
        if (din_valid && (cnt == CRC_LAST)) state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Data phase feeds the bit back through POLY; CRC phase just shifts the remainder out MSB first.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      crc_msb[i] = crc[i][CRC_W-1];
      crc_sh[i]  = {crc[i][CRC_W-2:0], 1'b0};
      crc_fb[i]  = crc_sh[i] ^ ((din[i] ^ crc[i][CRC_W-1]) ? POLY : '0);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      mode_q     <= 1'b0;
      len_q      <= '0;
      cnt        <= '0;
      crc        <= '0;
      crc_val_q  <= '0;
      crc_err    <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            mode_q    <= mode;
            len_q     <= blk_len;
            cnt       <= '0;
            crc       <= '0;
            crc_val_q <= '0;
            crc_err   <= '0;
          end
        end
        S_DATA: begin
          if (din_valid) begin
            crc <= crc_fb;
            if (data_last) begin
              crc_val_q <= crc_fb;
              cnt       <= '0;
            end else begin
              cnt <= cnt + LEN_W'(1);
            end
            if (!mode_q) begin
              dout       <= din;
              dout_valid <= 1'b1;
            end
          end
        end
        S_CRCP: begin
          if (din_valid) begin
            crc <= crc_sh;
            cnt <= cnt + LEN_W'(1);
            if (!mode_q) begin
              dout       <= crc_msb;
              dout_valid <= 1'b1;
            end else begin
              crc_err <= crc_err | (din ^ crc_msb);
            end
          end
        end
        S_DONE: begin
          if (!mode_q) crc_err <= '0;
        end
        default: ;
      endcase
    end
  end

  assign crc_val = crc_val_q;

endmodule
